// File: rtl/prbs7_capture_checker.sv
// PRBS-7 (x^7+x^6+1) capture-end checker: self-seeds from the incoming stream,
// verifies it, declares lock, then counts bit errors while locked.
module prbs7_capture_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           cur, nxt;
    logic [6:0]       lfsr, lfsr_n;
    logic [2:0]       seed_cnt, seed_n;
    logic [7:0]       match_cnt, match_n;
    logic [3:0]       consec_err, consec_n;
    logic             err_n;
    logic [CNT_W-1:0] cnt_n;
    logic             exp_bit;
    logic [6:0]       lfsr_din;
    logic [6:0]       lfsr_exp;

    assign exp_bit  = lfsr[6] ^ lfsr[5];
    assign lfsr_din = {lfsr[5:0], din};
    assign lfsr_exp = {lfsr[5:0], exp_bit};
    assign state    = cur;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        nxt      = cur;
        lfsr_n   = lfsr;
        seed_n   = seed_cnt;
        match_n  = match_cnt;
        consec_n = consec_err;
        err_n    = 1'b0;

        if (en) begin
            case (cur)
                SEED: begin
                    lfsr_n = lfsr_din;
                    if (seed_cnt == 3'd6) begin
                        seed_n = 3'd0;
                        // An all-zero window is a stuck stream: keep seeding.
                        if (lfsr_din != 7'd0) begin
                            nxt     = VERIFY;
                            match_n = 8'd0;
                        end
                    end else begin
                        seed_n = seed_cnt + 3'd1;
                    end
                end
                VERIFY: begin
                    lfsr_n = lfsr_exp;
                    if (din == exp_bit) begin
                        match_n = match_cnt + 8'd1;
                        if (match_n == 8'(LOCK_CNT)) begin
                            nxt      = LOCKED;
                            match_n  = 8'd0;
                            consec_n = 4'd0;
                        end
                    end else begin
                        nxt     = SEED;
                        seed_n  = 3'd0;
                        match_n = 8'd0;
                    end
                end
                LOCKED: begin
                    lfsr_n = lfsr_exp;
                    if (din == exp_bit) begin
                        consec_n = 4'd0;
                    end else begin
                        err_n    = 1'b1;
                        consec_n = consec_err + 4'd1;
                        if (consec_n == 4'(LOSS_CNT)) begin
                            nxt      = SEED;
                            consec_n = 4'd0;
                            seed_n   = 3'd0;
                        end
                    end
                end
                default: begin
                    nxt    = SEED;
                    seed_n = 3'd0;
                end
            endcase
        end

        // A clear coincident with a counted error leaves exactly that error.
        cnt_n = err_cnt;
        if (clr_err) begin
            cnt_n = err_n ? CNT_ONE : '0;
        end else if (err_n && (err_cnt != '1)) begin
            cnt_n = err_cnt + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= SEED;
            lfsr       <= 7'd0;
            seed_cnt   <= 3'd0;
            match_cnt  <= 8'd0;
            consec_err <= 4'd0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            cur        <= nxt;
            lfsr       <= lfsr_n;
            seed_cnt   <= seed_n;
            match_cnt  <= match_n;
            consec_err <= consec_n;
            locked     <= (nxt == LOCKED);
            err        <= err_n;
            err_cnt    <= cnt_n;
        end
    end

endmodule

// File: doc/prbs7_capture_checker.md
Name: prbs7_capture_checker

Overview:
- Capture-end checker for launch/capture timing test paths: the receiver of a PRBS-7 serial stream driven by a launch flop through a skewed clock tree.
- Self-synchronises to the incoming sequence, declares lock, then counts bit errors from hold/setup failures on the path.
- Sits at the capture flop output of each test path in the resizer hold/setup characterisation structures; results are read by the test harness.

Parameters:
LOCK_CNT, 16, consecutive matching samples after seeding required to declare lock (2..255)
LOSS_CNT, 4, consecutive mismatches while locked that force loss of lock (1..15)
CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  sample valid; when low, all state holds
din  input  1  captured serial bit, sampled when en=1
clr_err  input  1  synchronous clear of err_cnt
locked  output  1  high while in LOCKED state
err  output  1  one-cycle pulse per mismatching sample while locked
err_cnt  output  CNT_W  saturating count of locked-state mismatches
state  output  2  current FSM state (0 SEED, 1 VERIFY, 2 LOCKED)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: state=SEED, lfsr=0, seed_cnt=0, match_cnt=0, consec_err=0, locked=0, err=0, err_cnt=0. rst overrides en and clr_err.
- PRBS-7: polynomial x^7+x^6+1. Expected bit exp = lfsr[6]^lfsr[5]. Advance = {lfsr[5:0], bit}.
- All transitions below happen only on cycles with en=1. With en=0 everything holds, and err is 0.
- SEED:
  - Shift din into lfsr; seed_cnt increments.
  - On the 7th sample: if the resulting lfsr is nonzero, go to VERIFY with match_cnt=0. If it is all-zero (stuck stream), stay in SEED with seed_cnt=0.
- VERIFY:
  - Compare din to exp, then advance lfsr with exp (open loop).
  - Match: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED.
  - Mismatch: go to SEED, seed_cnt=0, match_cnt=0. err is not asserted and err_cnt is unchanged.
- LOCKED:
  - Compare din to exp, then advance lfsr with exp.
  - Match: consec_err=0.
  - Mismatch: err=1 the following cycle; err_cnt++, saturating at all-ones; consec_err++.
  - When consec_err reaches LOSS_CNT, go to SEED (locked drops) and clear consec_err. The error that triggers loss is still counted.
- Outputs are registered. locked rises in the cycle after the LOCK_CNT-th matching sample edge and falls in the cycle after the LOSS_CNT-th consecutive error edge.
- clr_err: err_cnt becomes 0. If a counted error occurs on the same edge, err_cnt becomes 1. clr_err does not affect state, lock, or the err pulse.
- Saturation: at err_cnt = 2^CNT_W-1, further errors still pulse err but the counter holds.
- rst asserted mid-operation: the state returns to reset values on the next edge regardless of state.

Test Plan:
1. rst, then 7 samples of 1 (lfsr=7'h7F), followed by the correct PRBS-7 continuation with en=1 every cycle -> state SEED→VERIFY after sample 7; locked=1 the cycle after sample 23; err_cnt=0.
2. Locked stream, flip one bit -> err pulses exactly 1 cycle, err_cnt=1, locked stays 1. Flip 4 consecutive bits -> err_cnt=5, locked=0, state=SEED.
3. Seed with 7 zeros, then a valid stream -> remains in SEED for the zero block and reseeds from the next 7 bits; lock occurs 16 matches later.
4. Toggle en with 50% random gaps during a locked stream -> same err_cnt as the gapless run; no err pulses while en=0.
5. CNT_W=4, inject 20 isolated single-bit errors (fewer than LOSS_CNT consecutive) -> err_cnt saturates at 15, err pulses 20 times, locked stays 1. Apply clr_err coincident with an error -> err_cnt=1.
6. rst asserted during VERIFY with match_cnt=10 -> next cycle state=SEED, all outputs 0. Relock requires a full 7+16 samples.
